// File: rtl/sequenciador_pkg.sv
// Shared definitions for the PC sequencing controller: state encodings, default output hold, width helper.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package sequenciador_pkg;

  localparam logic [1:0] S_RUN      = 2'd0;
  localparam logic [1:0] S_WAIT_IN  = 2'd1;
  localparam logic [1:0] S_WAIT_OUT = 2'd2;
  localparam logic [1:0] S_HALTED   = 2'd3;

  typedef enum logic [1:0] {
    ST_RUN      = S_RUN,
    ST_WAIT_IN  = S_WAIT_IN,
    ST_WAIT_OUT = S_WAIT_OUT,
    ST_HALTED   = S_HALTED
  } state_t;

  // Extra stall cycles after an output instruction, so the display stays readable.
  localparam int unsigned OUT_HOLD_DEF = 4;

  // Width of the hold counter: enough to hold OUT_HOLD, never narrower than one bit.
  function automatic int unsigned hold_width(input int unsigned hold);
    int unsigned w;
    w = $clog2(hold + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sequenciador_pc_contador_espera.sv
// Loadable down-counter with zero flag, used to stretch output instructions.
// Latency: load/decrement take effect on the next rising clock edge.
// Backpressure: none; decrement saturates at zero.
module contador_espera #(
  parameter int unsigned W = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Load has priority over decrement; decrement stops at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Counter register, cleared by reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/sequenciador_pc.sv
// PC / register-file sequencing FSM: halt, input wait, output stretch, retired-instruction count.
// Latency: pc_hold/pc_take/in_latch/wr_inhibit are combinational; state and count update each edge.
// Backpressure: in_valid is the only handshake; the core stalls (pc_hold) until it is seen in WAIT_IN.
module sequenciador_pc
  import sequenciador_pkg::*;
#(
  parameter int unsigned OUT_HOLD = OUT_HOLD_DEF,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             halt_op,
  input  logic             in_op,
  input  logic             out_op,
  input  logic             branch,
  input  logic             zero,
  input  logic             jmp,
  input  logic             jr,
  input  logic             in_valid,
  input  logic             resume,
  output logic             pc_hold,
  output logic             pc_take,
  output logic             in_ready,
  output logic             in_latch,
  output logic             wr_inhibit,
  output logic             out_valid,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] instr_count
);

  localparam int unsigned HOLD_W = hold_width(OUT_HOLD);
  localparam bit          HOLD_EN = (OUT_HOLD != 0);
  // The RUN cycle of the output instruction is the first stall cycle, so load one less.
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'((OUT_HOLD > 0) ? (OUT_HOLD - 1) : 0);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] instr_count_q, instr_count_d;

  logic hold_load, hold_dec, hold_zero;
  logic retire;
  logic pc_hold_c, pc_take_c, in_latch_c, wr_inhibit_c;

  contador_espera #(.W(HOLD_W)) u_contador_espera (
    .clock    (clock),
    .reset    (reset),
    .load     (hold_load),
    .dec      (hold_dec),
    .load_val (HOLD_LOAD),
    .zero     (hold_zero)
  );

  // Next-state and Mealy output decode; halt > input > output > normal in RUN.
  always_comb begin
    state_d      = state_q;
    pc_hold_c    = 1'b0;
    pc_take_c    = 1'b0;
    in_latch_c   = 1'b0;
    wr_inhibit_c = 1'b0;
    hold_load    = 1'b0;
    hold_dec     = 1'b0;
    retire       = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (halt_op) begin
          pc_hold_c    = 1'b1;
          wr_inhibit_c = 1'b1;
          state_d      = ST_HALTED;
        end else if (in_op) begin
          pc_hold_c    = 1'b1;
          wr_inhibit_c = 1'b1;
          state_d      = ST_WAIT_IN;
        end else if (out_op && HOLD_EN) begin
          // Display write goes ahead this cycle; only the PC is held.
          pc_hold_c = 1'b1;
          hold_load = 1'b1;
          state_d   = ST_WAIT_OUT;
        end else begin
          pc_take_c = (branch & zero) | jmp | jr;
          retire    = 1'b1;
        end
      end
      ST_WAIT_IN: begin
        if (in_valid) begin
          in_latch_c = 1'b1;
          retire     = 1'b1;
          state_d    = ST_RUN;
        end else begin
          pc_hold_c    = 1'b1;
          wr_inhibit_c = 1'b1;
        end
      end
      ST_WAIT_OUT: begin
        wr_inhibit_c = 1'b1;
        if (!hold_zero) begin
          pc_hold_c = 1'b1;
          hold_dec  = 1'b1;
        end else begin
          retire  = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_HALTED: begin
        wr_inhibit_c = 1'b1;
        if (resume) begin
          retire  = 1'b1;
          state_d = ST_RUN;
        end else begin
          pc_hold_c = 1'b1;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
    instr_count_d = retire ? (instr_count_q + CNT_W'(1)) : instr_count_q;
  end

  // State and retired-instruction counter registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_RUN;
      instr_count_q <= '0;
    end else begin
      state_q       <= state_d;
      instr_count_q <= instr_count_d;
    end
  end

  // Mealy outputs are forced low while reset is held so nothing is latched mid-abort.
  assign pc_hold     = reset & pc_hold_c;
  assign pc_take     = reset & pc_take_c;
  assign in_latch    = reset & in_latch_c;
  assign wr_inhibit  = reset & wr_inhibit_c;
  assign in_ready    = (state_q == ST_WAIT_IN);
  assign out_valid   = (state_q == ST_WAIT_OUT);
  assign state       = state_q;
  assign instr_count = instr_count_q;

endmodule

// File: tb/tb_sequenciador_pc.sv
// Directed-vector bench with scoreboard for sequenciador_pc (OUT_HOLD=4/CNT_W=32 and OUT_HOLD=0/CNT_W=4).
// Latency: each vector is checked in the same cycle its inputs are applied.
// Backpressure: n/a.
module tb_sequenciador_pc;

  logic clock;
  logic rst1_n, rst2_n;
  logic halt_op, in_op, out_op, branch, zero, jmp, jr, in_valid, resume;

  logic        pc_hold1, pc_take1, in_ready1, in_latch1, wr_inhibit1, out_valid1;
  logic [1:0]  state1;
  logic [31:0] cnt1;
  logic        pc_hold2, pc_take2, in_ready2, in_latch2, wr_inhibit2, out_valid2;
  logic [1:0]  state2;
  logic [3:0]  cnt2;

  // Input bit order: {halt_op,in_op,out_op,branch,zero,jmp,jr,in_valid,resume}
  localparam logic [8:0] NOP  = 9'b000000000;
  localparam logic [8:0] HALT = 9'b100000000;
  localparam logic [8:0] IN   = 9'b010000000;
  localparam logic [8:0] OUT  = 9'b001000000;
  localparam logic [8:0] BR   = 9'b000100000;
  localparam logic [8:0] ZR   = 9'b000010000;
  localparam logic [8:0] JMP  = 9'b000001000;
  localparam logic [8:0] JR   = 9'b000000100;
  localparam logic [8:0] IV   = 9'b000000010;
  localparam logic [8:0] RES  = 9'b000000001;
  // Output bit order: {pc_hold,pc_take,in_ready,in_latch,wr_inhibit,out_valid}
  localparam logic [5:0] O0   = 6'b000000;
  localparam logic [5:0] H    = 6'b100000;
  localparam logic [5:0] T    = 6'b010000;
  localparam logic [5:0] RDY  = 6'b001000;
  localparam logic [5:0] LAT  = 6'b000100;
  localparam logic [5:0] WI   = 6'b000010;
  localparam logic [5:0] OV   = 6'b000001;

  typedef struct {
    string       nm;
    bit          sel;
    logic [5:0]  o;
    logic [1:0]  s;
    logic [31:0] c;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  sequenciador_pc #(.OUT_HOLD(4), .CNT_W(32)) dut1 (
    .clock(clock), .reset(rst1_n), .halt_op(halt_op), .in_op(in_op), .out_op(out_op),
    .branch(branch), .zero(zero), .jmp(jmp), .jr(jr), .in_valid(in_valid), .resume(resume),
    .pc_hold(pc_hold1), .pc_take(pc_take1), .in_ready(in_ready1), .in_latch(in_latch1),
    .wr_inhibit(wr_inhibit1), .out_valid(out_valid1), .state(state1), .instr_count(cnt1)
  );

  sequenciador_pc #(.OUT_HOLD(0), .CNT_W(4)) dut2 (
    .clock(clock), .reset(rst2_n), .halt_op(halt_op), .in_op(in_op), .out_op(out_op),
    .branch(branch), .zero(zero), .jmp(jmp), .jr(jr), .in_valid(in_valid), .resume(resume),
    .pc_hold(pc_hold2), .pc_take(pc_take2), .in_ready(in_ready2), .in_latch(in_latch2),
    .wr_inhibit(wr_inhibit2), .out_valid(out_valid2), .state(state2), .instr_count(cnt2)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Apply one vector just after the rising edge and queue what the DUT must show this cycle.
  task automatic step(input string nm, input bit sel, input logic rst, input logic [8:0] iv,
                      input logic [5:0] eo, input logic [1:0] es, input int unsigned ec);
    exp_t e;
    @(posedge clock);
    #1;
    if (sel) rst2_n = rst;
    else     rst1_n = rst;
    {halt_op, in_op, out_op, branch, zero, jmp, jr, in_valid, resume} = iv;
    e.nm  = nm;
    e.sel = sel;
    e.o   = eo;
    e.s   = es;
    e.c   = ec;
    sb.push_back(e);
  endtask

  // Monitor: on each falling edge, compare the DUT against the oldest queued expectation.
  initial begin
    exp_t        e;
    logic [5:0]  ao;
    logic [1:0]  as;
    logic [31:0] ac;
    forever begin
      @(negedge clock);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        if (e.sel) begin
          ao = {pc_hold2, pc_take2, in_ready2, in_latch2, wr_inhibit2, out_valid2};
          as = state2;
          ac = {28'd0, cnt2};
        end else begin
          ao = {pc_hold1, pc_take1, in_ready1, in_latch1, wr_inhibit1, out_valid1};
          as = state1;
          ac = cnt1;
        end
        vectors++;
        if ((ao !== e.o) || (as !== e.s) || (ac !== e.c)) begin
          miscompares++;
          $display("FAIL %s: got out=%b state=%0d count=%0d, expected out=%b state=%0d count=%0d",
                   e.nm, ao, as, ac, e.o, e.s, e.c);
        end
      end
    end
  end

  initial begin
    rst1_n = 1'b0;
    rst2_n = 1'b0;
    {halt_op, in_op, out_op, branch, zero, jmp, jr, in_valid, resume} = NOP;

    // Reset dominates all inputs, then basic RUN decode.
    step("rst_halt", 0, 0, HALT, O0, 0, 0);
    step("rst_mix",  0, 0, HALT | IN | OUT | BR | ZR | JMP, O0, 0, 0);
    step("rel_nop",  0, 1, NOP, O0, 0, 0);
    step("nop",      0, 1, NOP, O0, 0, 1);
    step("beq_take", 0, 1, BR | ZR, T, 0, 2);
    step("beq_not",  0, 1, BR, O0, 0, 3);
    step("jmp",      0, 1, JMP, T, 0, 4);
    step("jr_halt",  0, 1, JR | HALT, H | WI, 0, 5);

    // HALTED for 10 cycles, resume on the 10th; stray in_valid/jmp ignored.
    for (int i = 0; i < 9; i++)
      step("halted", 0, 1, (i == 4) ? (IV | JMP) : NOP, H | WI, 3, 5);
    step("resume",     0, 1, RES, WI, 3, 5);
    step("resume_run", 0, 1, RES, O0, 0, 6);

    // Input wait: in_valid on the in_op cycle ignored, 5 low cycles, then accepted.
    step("in_op", 0, 1, IN | IV, H | WI, 0, 7);
    for (int i = 0; i < 5; i++)
      step("wait_in", 0, 1, (i == 2) ? (JMP | BR | ZR | RES) : NOP, RDY | H | WI, 1, 7);
    step("in_accept", 0, 1, IV, RDY | LAT, 1, 7);
    step("post_in",   0, 1, NOP, O0, 0, 8);

    // Output stretch: 4 held cycles, PC advances on the 5th.
    step("out_op", 0, 1, OUT, H, 0, 9);
    for (int i = 0; i < 3; i++)
      step("wait_out", 0, 1, (i == 1) ? (BR | ZR | IV) : NOP, H | WI | OV, 2, 9);
    step("out_done", 0, 1, NOP, WI | OV, 2, 9);
    step("post_out", 0, 1, NOP, O0, 0, 10);

    // Reset during WAIT_OUT aborts the wait; a fresh output stalls the full length.
    step("out_op2",   0, 1, OUT, H, 0, 11);
    step("wait_out2", 0, 1, NOP, H | WI | OV, 2, 11);
    step("rst_wout",  0, 0, IV, O0, 0, 0);
    step("rel2",      0, 1, NOP, O0, 0, 0);
    step("out_op3",   0, 1, OUT, H, 0, 1);
    for (int i = 0; i < 3; i++)
      step("wait_out3", 0, 1, NOP, H | WI | OV, 2, 1);
    step("out_done3", 0, 1, NOP, WI | OV, 2, 1);
    step("post_out3", 0, 1, NOP, O0, 0, 2);

    // Reset during WAIT_IN with in_valid high: nothing latched.
    step("in_op2",   0, 1, IN, H | WI, 0, 3);
    step("wait_in2", 0, 1, NOP, RDY | H | WI, 1, 3);
    step("rst_win",  0, 0, IV, O0, 0, 0);
    step("rel3",     0, 1, IV, O0, 0, 0);
    step("post_rel3", 0, 1, NOP, O0, 0, 1);

    // Second instance: OUT_HOLD=0 means no stall; 4-bit counter wraps.
    step("d2_rst",    1, 0, HALT, O0, 0, 0);
    step("d2_rel",    1, 1, NOP, O0, 0, 0);
    step("d2_out",    1, 1, OUT, O0, 0, 1);
    step("d2_out_br", 1, 1, OUT | BR | ZR, T, 0, 2);
    for (int k = 3; k < 16; k++)
      step("d2_count", 1, 1, NOP, O0, 0, k);
    step("d2_wrap",   1, 1, NOP, O0, 0, 0);

    repeat (3) @(posedge clock);
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
